// File: rtl/turf_arb_pkg.sv
// Shared types and constants for the TURF register-bus arbiter.
// Holds FSM state encoding, command payload layout and master indices.
package turf_arb_pkg;

   localparam int unsigned ADDR_W  = 6;
   localparam int unsigned BANK_W  = 2;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned WAIT_W  = 8;
   localparam int unsigned TOCNT_W = 16;
   localparam int unsigned NUM_M   = 2;

   localparam logic M0_IDX = 1'b0;
   localparam logic M1_IDX = 1'b1;

   localparam logic [DATA_W-1:0] TIMEOUT_DATA_DEF = 32'hDEAD_DEAD;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_WAIT  = 2'd2,
      ST_DONE  = 2'd3
   } arb_state_e;

   // Command fields forwarded to the TURF side and held for the whole transaction
   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [BANK_W-1:0] bank;
      logic [DATA_W-1:0] dat;
   } turf_cmd_t;

   function automatic logic [TOCNT_W-1:0] sat_inc(input logic [TOCNT_W-1:0] v);
      return (&v) ? v : v + TOCNT_W'(1);
   endfunction

endpackage

// File: rtl/turf_bus_arbiter_if.sv
// Per-requester handshake bundle: a master raises req with a command and
// receives a one-cycle ack with error flag and read data.
interface turf_bus_arbiter_if;
   import turf_arb_pkg::*;

   logic              req;
   logic              wr;
   logic [ADDR_W-1:0] addr;
   logic [BANK_W-1:0] bank;
   logic [DATA_W-1:0] wdat;
   logic              ack;
   logic              err;
   logic [DATA_W-1:0] rdat;

   modport master (
      output req, wr, addr, bank, wdat,
      input  ack, err, rdat
   );

   modport slave (
      input  req, wr, addr, bank, wdat,
      output ack, err, rdat
   );

endinterface

// File: rtl/turf_arb_rr2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the
// master that did not own the previous transaction.
module turf_arb_rr2 (
   input  logic [1:0] req_i,
   input  logic       last_grant_i,
   output logic [1:0] gnt_c_o
);

   always_comb begin
      gnt_c_o = 2'b00;
      case (req_i)
         2'b01:   gnt_c_o = 2'b01;
         2'b10:   gnt_c_o = 2'b10;
         2'b11:   gnt_c_o = last_grant_i ? 2'b01 : 2'b10;
         default: gnt_c_o = 2'b00;
      endcase
   end

endmodule

// File: rtl/turf_bus_arbiter.sv
// Shares the TURF register-access path between the PLX decoder (master 0)
// and the housekeeping poller (master 1), one transaction at a time.
module turf_bus_arbiter
   import turf_arb_pkg::*;
#(
   parameter int unsigned       TIMEOUT_CYCLES = 255,
   parameter logic [DATA_W-1:0] TIMEOUT_DATA   = TIMEOUT_DATA_DEF
) (
   input  logic                clk_i,
   input  logic                rst_i,
   turf_bus_arbiter_if.slave   m0,
   turf_bus_arbiter_if.slave   m1,
   output logic                s_wr_o,
   output logic                s_rd_o,
   output logic [ADDR_W-1:0]   s_addr_o,
   output logic [BANK_W-1:0]   s_bank_o,
   output logic [DATA_W-1:0]   s_dat_o,
   input  logic [DATA_W-1:0]   s_dat_i,
   input  logic                s_ack_i,
   output logic [NUM_M-1:0]    grant_o,
   output logic [TOCNT_W-1:0]  timeout_cnt_o
);

   localparam int unsigned WAIT_CW = WAIT_W + 1;
   localparam logic [WAIT_CW-1:0] WAIT_LIM = WAIT_CW'(TIMEOUT_CYCLES);

   arb_state_e          state_q,  state_d;
   turf_cmd_t           cmd_q,    cmd_d;
   logic                s_wr_q,   s_wr_d;
   logic                s_rd_q,   s_rd_d;
   logic [NUM_M-1:0]    grant_q,  grant_d;
   logic                last_q,   last_d;
   logic [WAIT_W-1:0]   wait_q,   wait_d;
   logic [NUM_M-1:0]    ack_q,    ack_d;
   logic [NUM_M-1:0]    err_q,    err_d;
   logic [DATA_W-1:0]   rdat0_q,  rdat0_d;
   logic [DATA_W-1:0]   rdat1_q,  rdat1_d;
   logic [TOCNT_W-1:0]  tocnt_q,  tocnt_d;

   logic [NUM_M-1:0]    pick_c;
   turf_cmd_t           sel_cmd_c;
   logic                sel_wr_c;
   logic                fin_c;
   logic                fin_err_c;
   logic [DATA_W-1:0]   fin_dat_c;
   logic                wait_hit_c;

   turf_arb_rr2 u_rr2 (
      .req_i        ({m1.req, m0.req}),
      .last_grant_i (last_q),
      .gnt_c_o      (pick_c)
   );

   // Command of whichever master the round-robin picked this cycle
   always_comb begin
      if (pick_c[M1_IDX]) begin
         sel_wr_c  = m1.wr;
         sel_cmd_c = '{addr: m1.addr, bank: m1.bank, dat: m1.wdat};
      end else begin
         sel_wr_c  = m0.wr;
         sel_cmd_c = '{addr: m0.addr, bank: m0.bank, dat: m0.wdat};
      end
   end

   assign wait_hit_c = (WAIT_CW'(wait_q) + WAIT_CW'(1)) == WAIT_LIM;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         cmd_q   <= '0;
         s_wr_q  <= 1'b0;
         s_rd_q  <= 1'b0;
         grant_q <= '0;
         last_q  <= M1_IDX;
         wait_q  <= '0;
         ack_q   <= '0;
         err_q   <= '0;
         rdat0_q <= '0;
         rdat1_q <= '0;
         tocnt_q <= '0;
      end else begin
         state_q <= state_d;
         cmd_q   <= cmd_d;
         s_wr_q  <= s_wr_d;
         s_rd_q  <= s_rd_d;
         grant_q <= grant_d;
         last_q  <= last_d;
         wait_q  <= wait_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         rdat0_q <= rdat0_d;
         rdat1_q <= rdat1_d;
         tocnt_q <= tocnt_d;
      end
   end

   // Next-state: completion is resolved in ISSUE/WAIT so the ack lands in DONE
   always_comb begin
      state_d   = state_q;
      cmd_d     = cmd_q;
      s_wr_d    = 1'b0;
      s_rd_d    = 1'b0;
      grant_d   = grant_q;
      last_d    = last_q;
      wait_d    = wait_q;
      ack_d     = '0;
      err_d     = '0;
      rdat0_d   = rdat0_q;
      rdat1_d   = rdat1_q;
      tocnt_d   = tocnt_q;
      fin_c     = 1'b0;
      fin_err_c = 1'b0;
      fin_dat_c = s_dat_i;

      case (state_q)
         ST_IDLE: begin
            if (|pick_c) begin
               grant_d = pick_c;
               last_d  = pick_c[M1_IDX];
               cmd_d   = sel_cmd_c;
               s_wr_d  = sel_wr_c;
               s_rd_d  = ~sel_wr_c;
               state_d = ST_ISSUE;
            end
         end
         ST_ISSUE: begin
            if (s_ack_i) begin
               fin_c = 1'b1;
            end else begin
               wait_d  = '0;
               state_d = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (s_ack_i) begin
               fin_c = 1'b1;
            end else if (wait_hit_c) begin
               fin_c     = 1'b1;
               fin_err_c = 1'b1;
               fin_dat_c = TIMEOUT_DATA;
               tocnt_d   = sat_inc(tocnt_q);
            end else begin
               wait_d = wait_q + WAIT_W'(1);
            end
         end
         ST_DONE: begin
            grant_d = '0;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Writes load the result register too, keeping the completion path uniform
      if (fin_c) begin
         state_d = ST_DONE;
         ack_d   = grant_q;
         err_d   = grant_q & {NUM_M{fin_err_c}};
         if (grant_q[M0_IDX]) rdat0_d = fin_dat_c;
         if (grant_q[M1_IDX]) rdat1_d = fin_dat_c;
      end
   end

   assign m0.ack  = ack_q[M0_IDX];
   assign m0.err  = err_q[M0_IDX];
   assign m0.rdat = rdat0_q;
   assign m1.ack  = ack_q[M1_IDX];
   assign m1.err  = err_q[M1_IDX];
   assign m1.rdat = rdat1_q;

   assign s_wr_o        = s_wr_q;
   assign s_rd_o        = s_rd_q;
   assign s_addr_o      = cmd_q.addr;
   assign s_bank_o      = cmd_q.bank;
   assign s_dat_o       = cmd_q.dat;
   assign grant_o       = grant_q;
   assign timeout_cnt_o = tocnt_q;

endmodule

// File: tb/tb_turf_bus_arbiter.sv
// Directed and randomized bench for turf_bus_arbiter against a
// transaction-level reference model.
module tb_turf_bus_arbiter;
   import turf_arb_pkg::*;

   localparam int unsigned TO    = 4;
   localparam logic [31:0] TDATA = 32'hDEAD_DEAD;

   logic        clk_i = 1'b0;
   logic        rst_i;
   logic        s_wr_o, s_rd_o;
   logic [5:0]  s_addr_o;
   logic [1:0]  s_bank_o;
   logic [31:0] s_dat_o;
   logic [31:0] s_dat_i;
   logic        s_ack_i;
   logic [1:0]  grant_o;
   logic [15:0] timeout_cnt_o;

   turf_bus_arbiter_if m0_if ();
   turf_bus_arbiter_if m1_if ();

   turf_bus_arbiter #(
      .TIMEOUT_CYCLES (TO),
      .TIMEOUT_DATA   (TDATA)
   ) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .m0            (m0_if),
      .m1            (m1_if),
      .s_wr_o        (s_wr_o),
      .s_rd_o        (s_rd_o),
      .s_addr_o      (s_addr_o),
      .s_bank_o      (s_bank_o),
      .s_dat_o       (s_dat_o),
      .s_dat_i       (s_dat_i),
      .s_ack_i       (s_ack_i),
      .grant_o       (grant_o),
      .timeout_cnt_o (timeout_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   int checks   = 0;
   int failures = 0;

   // Reference model: pending requests and expected architectural outputs
   bit          pend   [2];
   bit          p_wr   [2];
   logic [5:0]  p_addr [2];
   logic [1:0]  p_bank [2];
   logic [31:0] p_dat  [2];
   logic [31:0] exp_rdat [2];
   int          last_g;
   logic [5:0]  e_addr;
   logic [1:0]  e_bank;
   logic [31:0] e_dat;
   int          exp_to;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive_reqs();
      m0_if.req  = pend[0];  m0_if.wr   = p_wr[0];
      m0_if.addr = p_addr[0]; m0_if.bank = p_bank[0]; m0_if.wdat = p_dat[0];
      m1_if.req  = pend[1];  m1_if.wr   = p_wr[1];
      m1_if.addr = p_addr[1]; m1_if.bank = p_bank[1]; m1_if.wdat = p_dat[1];
   endtask

   task automatic raise(input int m, input bit wr, input logic [5:0] a,
                        input logic [1:0] b, input logic [31:0] d);
      pend[m] = 1'b1; p_wr[m] = wr; p_addr[m] = a; p_bank[m] = b; p_dat[m] = d;
      drive_reqs();
   endtask

   task automatic raise_rand(input int m);
      raise(m, 1'($urandom), 6'($urandom), 2'($urandom), $urandom);
   endtask

   task automatic model_reset();
      pend[0] = 1'b0; pend[1] = 1'b0;
      exp_rdat[0] = '0; exp_rdat[1] = '0;
      last_g = 1; e_addr = '0; e_bank = '0; e_dat = '0; exp_to = 0;
      drive_reqs();
   endtask

   task automatic check_all(input string tag, input int ack_m, input bit e_err,
                            input bit e_wr, input bit e_rd, input logic [1:0] e_gnt);
      chk({tag, ":m0_ack"}, 32'(m0_if.ack), 32'(ack_m == 0));
      chk({tag, ":m1_ack"}, 32'(m1_if.ack), 32'(ack_m == 1));
      if (ack_m == 0) chk({tag, ":m0_err"}, 32'(m0_if.err), 32'(e_err));
      if (ack_m == 1) chk({tag, ":m1_err"}, 32'(m1_if.err), 32'(e_err));
      chk({tag, ":m0_dat"}, m0_if.rdat, exp_rdat[0]);
      chk({tag, ":m1_dat"}, m1_if.rdat, exp_rdat[1]);
      chk({tag, ":s_wr"}, 32'(s_wr_o), 32'(e_wr));
      chk({tag, ":s_rd"}, 32'(s_rd_o), 32'(e_rd));
      chk({tag, ":s_addr"}, 32'(s_addr_o), 32'(e_addr));
      chk({tag, ":s_bank"}, 32'(s_bank_o), 32'(e_bank));
      chk({tag, ":s_dat"}, s_dat_o, e_dat);
      chk({tag, ":grant"}, 32'(grant_o), 32'(e_gnt));
      chk({tag, ":to_cnt"}, 32'(timeout_cnt_o), 32'(exp_to));
   endtask

   // One arbitration round starting in an IDLE cycle; d = cycles from strobe to s_ack_i
   task automatic round(input int d, input bit ok, input logic [31:0] ack_data);
      int          w;
      int          n;
      logic [31:0] r;
      logic [1:0]  g;
      if (pend[0] && pend[1]) w = 1 - last_g;
      else                    w = pend[1] ? 1 : 0;
      last_g = w;
      g      = (w == 1) ? 2'b10 : 2'b01;
      e_addr = p_addr[w]; e_bank = p_bank[w]; e_dat = p_dat[w];
      s_ack_i = ($urandom_range(0, 3) == 0);
      s_dat_i = $urandom;
      cyc();
      check_all("issue", -1, 1'b0, p_wr[w], !p_wr[w], g);
      n = ok ? d : int'(TO);
      for (int j = 0; j <= n; j++) begin
         r       = (ok && j == n) ? ack_data : $urandom;
         s_dat_i = r;
         s_ack_i = ok && (j == n);
         cyc();
         if (j < n) begin
            check_all("wait", -1, 1'b0, 1'b0, 1'b0, g);
         end else begin
            exp_rdat[w] = ok ? r : TDATA;
            if (!ok && exp_to < 65535) exp_to++;
            check_all("done", w, !ok, 1'b0, 1'b0, g);
         end
      end
      pend[w] = 1'b0;
      drive_reqs();
      s_ack_i = 1'($urandom);
      s_dat_i = $urandom;
      cyc();
      check_all("post", -1, 1'b0, 1'b0, 1'b0, 2'b00);
      s_ack_i = 1'b0;
   endtask

   task automatic idle_cycle();
      s_ack_i = 1'($urandom);
      s_dat_i = $urandom;
      cyc();
      check_all("idle", -1, 1'b0, 1'b0, 1'b0, 2'b00);
      s_ack_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      int d;
      rst_i   = 1'b1;
      s_ack_i = 1'b0;
      s_dat_i = '0;
      p_wr[0] = 1'b0; p_addr[0] = '0; p_bank[0] = '0; p_dat[0] = '0;
      p_wr[1] = 1'b0; p_addr[1] = '0; p_bank[1] = '0; p_dat[1] = '0;
      model_reset();
      repeat (3) cyc();
      check_all("reset", -1, 1'b0, 1'b0, 1'b0, 2'b00);
      rst_i = 1'b0;
      cyc();
      check_all("reset_rel", -1, 1'b0, 1'b0, 1'b0, 2'b00);

      // M0 read, ack three cycles after the strobe
      raise(0, 1'b0, 6'h05, 2'd2, 32'h0);
      round(3, 1'b1, 32'h1234_5678);
      chk("t1_m0_dat", m0_if.rdat, 32'h1234_5678);

      // Both masters requesting continuously: grants must alternate
      raise_rand(0);
      raise_rand(1);
      for (int k = 0; k < 4; k++) begin
         round(1, 1'b1, $urandom);
         raise_rand(last_g);
      end
      while (pend[0] || pend[1]) round(1, 1'b1, $urandom);

      // M1 write with no acknowledge -> timeout completion
      raise(1, 1'b1, 6'h2A, 2'd1, 32'hCAFE_F00D);
      round(0, 1'b0, 32'h0);
      chk("t3_m1_dat", m1_if.rdat, 32'hDEAD_DEAD);
      chk("t3_to_cnt", 32'(timeout_cnt_o), 32'd1);

      // Acknowledge in the same cycle as the write strobe
      raise(0, 1'b1, 6'h11, 2'd3, 32'hA5A5_5A5A);
      round(0, 1'b1, 32'h0BAD_F00D);

      // Stray acknowledges with nobody requesting
      repeat (4) idle_cycle();

      // Randomized traffic
      repeat (150) begin
         for (int m = 0; m < 2; m++)
            if (!pend[m] && ($urandom_range(0, 1) == 1)) raise_rand(m);
         if (!pend[0] && !pend[1]) begin
            idle_cycle();
         end else begin
            d = int'($urandom_range(0, TO + 2));
            round(d, d <= int'(TO), $urandom);
         end
      end
      while (pend[0] || pend[1]) round(0, 1'b1, $urandom);

      // Reset while waiting for the TURF acknowledge
      raise(0, 1'b0, 6'h3C, 2'd1, 32'h1357_9BDF);
      last_g = 0; e_addr = 6'h3C; e_bank = 2'd1; e_dat = 32'h1357_9BDF;
      cyc();
      check_all("t6_issue", -1, 1'b0, 1'b0, 1'b1, 2'b01);
      cyc();
      check_all("t6_wait", -1, 1'b0, 1'b0, 1'b0, 2'b01);
      rst_i = 1'b1;
      model_reset();
      cyc();
      check_all("t6_rst", -1, 1'b0, 1'b0, 1'b0, 2'b00);
      rst_i = 1'b0;
      cyc();
      check_all("t6_after", -1, 1'b0, 1'b0, 1'b0, 2'b00);
      raise(0, 1'b0, 6'h07, 2'd0, 32'h0);
      round(2, 1'b1, 32'hFEED_BEEF);
      chk("t6_fresh_dat", m0_if.rdat, 32'hFEED_BEEF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
